// File: rtl/fixed_linear_param_source.sv
// Streams stored weight words (and optionally bias words) in the order a PARALLELISM-wide
// linear layer consumes them: for each sample, for each output block, for each input beat.
module fixed_linear_param_source #(
  parameter  int PARALLELISM  = 2,
  parameter  int IN_0_SIZE    = 4,
  parameter  int IN_0_DEPTH   = 3,
  parameter  int OUT_DEPTH    = 2,
  parameter  int WEIGHT_WIDTH = 16,
  parameter  int BIAS_WIDTH   = 32,
  parameter  int HAS_BIAS     = 0,
  parameter  int CNT_WIDTH    = 16,
  localparam int WEIGHT_SIZE  = IN_0_SIZE * PARALLELISM,
  localparam int W_DEPTH      = OUT_DEPTH * IN_0_DEPTH,
  localparam int W_AW         = (W_DEPTH > 1) ? $clog2(W_DEPTH) : 1,
  localparam int B_AW         = (OUT_DEPTH > 1) ? $clog2(OUT_DEPTH) : 1
) (
  input  logic                                      clk,
  input  logic                                      rst,
  input  logic                                      w_wr_en,
  input  logic [W_AW-1:0]                           w_wr_addr,
  input  logic [WEIGHT_SIZE-1:0][WEIGHT_WIDTH-1:0]  w_wr_data,
  input  logic                                      b_wr_en,
  input  logic [B_AW-1:0]                           b_wr_addr,
  input  logic [PARALLELISM-1:0][BIAS_WIDTH-1:0]    b_wr_data,
  output logic                                      wr_ready,
  input  logic                                      start,
  input  logic [CNT_WIDTH-1:0]                      n_samples,
  output logic                                      busy,
  output logic                                      done,
  output logic [WEIGHT_SIZE-1:0][WEIGHT_WIDTH-1:0]  weight,
  output logic                                      weight_valid,
  input  logic                                      weight_ready,
  output logic [PARALLELISM-1:0][BIAS_WIDTH-1:0]    bias,
  output logic                                      bias_valid,
  input  logic                                      bias_ready
);

  localparam int              DW      = (IN_0_DEPTH > 1) ? $clog2(IN_0_DEPTH) : 1;
  localparam logic [DW-1:0]   D_LAST  = DW'(IN_0_DEPTH - 1);
  localparam logic [B_AW-1:0] O_LAST  = B_AW'(OUT_DEPTH - 1);
  localparam bit              BIAS_EN = (HAS_BIAS != 0);

  typedef logic [WEIGHT_SIZE-1:0][WEIGHT_WIDTH-1:0] w_word_t;
  typedef logic [PARALLELISM-1:0][BIAS_WIDTH-1:0]   b_word_t;
  typedef enum logic {IDLE, RUN} state_e;

  state_e               state_q, state_d;
  logic                 done_q, done_d, start_run;
  logic [CNT_WIDTH-1:0] n_q, cur_n, n_last;
  logic                 w_fin_q, b_fin_q;

  // ---------------- control FSM ----------------
  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    state_d   = state_q;
    done_d    = 1'b0;
    start_run = 1'b0;
    case (state_q)
      IDLE: if (start) begin
        if (n_samples != '0) begin
          state_d   = RUN;
          start_run = 1'b1;
        end else begin
          done_d = 1'b1;
        end
      end
      RUN: if (w_fin_q && (b_fin_q || !BIAS_EN)) begin
        state_d = IDLE;
        done_d  = 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      done_q  <= 1'b0;
      n_q     <= '0;
    end else begin
      state_q <= state_d;
      done_q  <= done_d;
      if (start_run) n_q <= n_samples;
    end
  end

  assign busy     = (state_q == RUN);
  assign wr_ready = (state_q == IDLE);
  assign done     = done_q;

  // The launch cycle already issues the first read, so it sees n_samples directly.
  assign cur_n  = start_run ? n_samples : n_q;
  assign n_last = cur_n - CNT_WIDTH'(1);

  // ---------------- weight channel ----------------
  w_word_t              w_mem [W_DEPTH];
  w_word_t              w_rd_q, weight_q;
  logic                 w_iss_q, w_rd_vld_q, w_rd_last_q, weight_valid_q, w_out_last_q;
  logic [DW-1:0]        w_d_q, w_cd;
  logic [B_AW-1:0]      w_o_q, w_co;
  logic [CNT_WIDTH-1:0] w_s_q, w_cs;
  logic [W_AW-1:0]      w_a_q, w_ca;
  logic                 w_load, w_issue, w_go, w_d_wrap, w_o_wrap, w_final;

  always_comb begin
    w_load   = w_rd_vld_q && (!weight_valid_q || weight_ready);
    w_issue  = w_iss_q && (!w_rd_vld_q || w_load);
    w_go     = start_run || w_issue;
    w_cd     = start_run ? '0 : w_d_q;
    w_co     = start_run ? '0 : w_o_q;
    w_cs     = start_run ? '0 : w_s_q;
    w_ca     = start_run ? '0 : w_a_q;
    w_d_wrap = (w_cd == D_LAST);
    w_o_wrap = w_d_wrap && (w_co == O_LAST);
    w_final  = w_o_wrap && (w_cs == n_last);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      w_iss_q        <= 1'b0;
      w_d_q          <= '0;
      w_o_q          <= '0;
      w_s_q          <= '0;
      w_a_q          <= '0;
      w_rd_vld_q     <= 1'b0;
      w_rd_last_q    <= 1'b0;
      weight_q       <= '0;
      weight_valid_q <= 1'b0;
      w_out_last_q   <= 1'b0;
      w_fin_q        <= 1'b0;
    end else begin
      if (start_run)                                          w_fin_q <= 1'b0;
      else if (weight_valid_q && weight_ready && w_out_last_q) w_fin_q <= 1'b1;
      if (w_go) begin
        w_iss_q     <= !w_final;
        w_d_q       <= w_d_wrap ? '0 : w_cd + DW'(1);
        w_o_q       <= w_o_wrap ? '0 : (w_d_wrap ? w_co + B_AW'(1) : w_co);
        w_s_q       <= w_o_wrap ? w_cs + CNT_WIDTH'(1) : w_cs;
        w_a_q       <= w_o_wrap ? '0 : w_ca + W_AW'(1);
        w_rd_last_q <= w_final;
      end
      if (w_go)        w_rd_vld_q <= 1'b1;
      else if (w_load) w_rd_vld_q <= 1'b0;
      if (w_load) begin
        weight_q       <= w_rd_q;
        weight_valid_q <= 1'b1;
        w_out_last_q   <= w_rd_last_q;
      end else if (weight_ready) begin
        weight_valid_q <= 1'b0;
      end
    end
  end

  // ---------------- bias channel ----------------
  b_word_t              b_mem [OUT_DEPTH];
  b_word_t              b_rd_q, bias_q;
  logic                 b_iss_q, b_rd_vld_q, b_rd_last_q, bias_valid_q, b_out_last_q;
  logic [B_AW-1:0]      b_o_q, b_co;
  logic [CNT_WIDTH-1:0] b_s_q, b_cs;
  logic                 b_start, b_load, b_issue, b_go, b_o_wrap, b_final;

  always_comb begin
    b_start  = start_run && BIAS_EN;
    b_load   = b_rd_vld_q && (!bias_valid_q || bias_ready);
    b_issue  = b_iss_q && (!b_rd_vld_q || b_load);
    b_go     = b_start || b_issue;
    b_co     = b_start ? '0 : b_o_q;
    b_cs     = b_start ? '0 : b_s_q;
    b_o_wrap = (b_co == O_LAST);
    b_final  = b_o_wrap && (b_cs == n_last);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      b_iss_q      <= 1'b0;
      b_o_q        <= '0;
      b_s_q        <= '0;
      b_rd_vld_q   <= 1'b0;
      b_rd_last_q  <= 1'b0;
      bias_q       <= '0;
      bias_valid_q <= 1'b0;
      b_out_last_q <= 1'b0;
      b_fin_q      <= 1'b0;
    end else begin
      if (start_run)                                      b_fin_q <= 1'b0;
      else if (bias_valid_q && bias_ready && b_out_last_q) b_fin_q <= 1'b1;
      if (b_go) begin
        b_iss_q     <= !b_final;
        b_o_q       <= b_o_wrap ? '0 : b_co + B_AW'(1);
        b_s_q       <= b_o_wrap ? b_cs + CNT_WIDTH'(1) : b_cs;
        b_rd_last_q <= b_final;
      end
      if (b_go)        b_rd_vld_q <= 1'b1;
      else if (b_load) b_rd_vld_q <= 1'b0;
      if (b_load) begin
        bias_q       <= b_rd_q;
        bias_valid_q <= 1'b1;
        b_out_last_q <= b_rd_last_q;
      end else if (bias_ready) begin
        bias_valid_q <= 1'b0;
      end
    end
  end

  // NOTE: the stores and their read registers are not reset; the valid flags gate them.
  always_ff @(posedge clk) begin
    if (w_wr_en && wr_ready) w_mem[w_wr_addr] <= w_wr_data;
    if (b_wr_en && wr_ready) b_mem[b_wr_addr] <= b_wr_data;
    if (w_go)                w_rd_q <= w_mem[w_ca];
    if (b_go)                b_rd_q <= b_mem[b_co];
  end

  assign weight       = weight_q;
  assign weight_valid = weight_valid_q;
  assign bias         = bias_q;
  assign bias_valid   = bias_valid_q;

endmodule

// File: tb/tb_fixed_linear_param_source.sv
// Directed bench for fixed_linear_param_source: one instance without bias, one with bias,
// sharing the store write bus, launch controls and weight_ready.
module tb_fixed_linear_param_source;

  localparam int P = 2, IS = 4, ID = 3, OD = 2, WW = 16, BW = 32, CW = 16;
  localparam int WS = IS * P, W_AW = 3, B_AW = 1;

  typedef logic [WS-1:0][WW-1:0] wword_t;
  typedef logic [P-1:0][BW-1:0]  bword_t;

  logic            clk = 1'b0, rst = 1'b0;
  logic            w_wr_en = 1'b0, b_wr_en = 1'b0;
  logic [W_AW-1:0] w_wr_addr = '0;
  logic [B_AW-1:0] b_wr_addr = '0;
  wword_t          w_wr_data = '0;
  bword_t          b_wr_data = '0;
  logic            start = 1'b0;
  logic [CW-1:0]   n_samples = '0;
  logic            weight_ready = 1'b0, bias_ready = 1'b0;

  logic   nb_wr_ready, nb_busy, nb_done, nb_wv, nb_bv;
  wword_t nb_w;
  bword_t nb_b;
  logic   hb_wr_ready, hb_busy, hb_done, hb_wv, hb_bv;
  wword_t hb_w;
  bword_t hb_b;

  int n_checks = 0, n_fail = 0;

  always #5 clk = ~clk;

  fixed_linear_param_source #(.HAS_BIAS(0)) u_nb (
    .clk(clk), .rst(rst),
    .w_wr_en(w_wr_en), .w_wr_addr(w_wr_addr), .w_wr_data(w_wr_data),
    .b_wr_en(b_wr_en), .b_wr_addr(b_wr_addr), .b_wr_data(b_wr_data),
    .wr_ready(nb_wr_ready), .start(start), .n_samples(n_samples),
    .busy(nb_busy), .done(nb_done),
    .weight(nb_w), .weight_valid(nb_wv), .weight_ready(weight_ready),
    .bias(nb_b), .bias_valid(nb_bv), .bias_ready(bias_ready)
  );

  fixed_linear_param_source #(.HAS_BIAS(1)) u_hb (
    .clk(clk), .rst(rst),
    .w_wr_en(w_wr_en), .w_wr_addr(w_wr_addr), .w_wr_data(w_wr_data),
    .b_wr_en(b_wr_en), .b_wr_addr(b_wr_addr), .b_wr_data(b_wr_data),
    .wr_ready(hb_wr_ready), .start(start), .n_samples(n_samples),
    .busy(hb_busy), .done(hb_done),
    .weight(hb_w), .weight_valid(hb_wv), .weight_ready(weight_ready),
    .bias(hb_b), .bias_valid(hb_bv), .bias_ready(bias_ready)
  );

  function automatic wword_t exp_w(input int a);
    wword_t r;
    for (int k = 0; k < WS; k++) r[k] = WW'(16 * a + k);
    return r;
  endfunction

  function automatic bword_t exp_b(input int o);
    bword_t r;
    r[1] = BW'(100 + o);
    r[0] = BW'(200 + o);
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One n_samples=1 run with ready high; expects words 0..5 and a single done pulse.
  task automatic stream_run(input string tag);
    int idx = 0;
    int dones = 0;
    weight_ready = 1'b1;
    n_samples    = CW'(1);
    start        = 1'b1;
    tick();
    start = 1'b0;
    for (int c = 1; c < 30 && dones == 0; c++) begin
      if (nb_wv) begin
        check({tag, "_word"}, 256'(nb_w), 256'(exp_w(idx)));
        idx++;
      end
      if (nb_done) dones++;
      tick();
    end
    check({tag, "_count"}, 256'(idx), 256'(6));
    check({tag, "_done"}, 256'(dones), 256'(1));
  endtask

  initial begin
    int idx, dones, wc, bc, hb_dones;

    // reset state
    rst = 1'b0;
    repeat (2) tick();
    check("rst_nb_wvalid", 256'(nb_wv), 256'(0));
    check("rst_hb_bvalid", 256'(hb_bv), 256'(0));
    check("rst_busy", 256'(nb_busy), 256'(0));
    check("rst_done", 256'(hb_done), 256'(0));
    check("rst_weight", 256'(hb_w), 256'(0));
    check("rst_bias", 256'(hb_b), 256'(0));
    check("rst_nb_wr_ready", 256'(nb_wr_ready), 256'(1));
    check("rst_hb_wr_ready", 256'(hb_wr_ready), 256'(1));
    rst = 1'b1;
    tick();

    // load stores; the first two cycles also write bias words alongside weights
    for (int a = 0; a < OD * ID; a++) begin
      w_wr_en   = 1'b1;
      w_wr_addr = W_AW'(a);
      w_wr_data = exp_w(a);
      b_wr_en   = (a < OD);
      b_wr_addr = B_AW'(a % OD);
      b_wr_data = exp_b(a % OD);
      tick();
    end
    w_wr_en = 1'b0;
    b_wr_en = 1'b0;

    // single sample, ready high: exact cycle timing
    weight_ready = 1'b1;
    bias_ready   = 1'b1;
    n_samples    = CW'(1);
    start        = 1'b1;
    tick();
    start = 1'b0;
    for (int c = 1; c <= 10; c++) begin
      check($sformatf("n1_valid_c%0d", c), 256'(nb_wv), 256'(c >= 2 && c <= 7));
      if (c >= 2 && c <= 7) check($sformatf("n1_word_c%0d", c), 256'(nb_w), 256'(exp_w(c - 2)));
      check($sformatf("n1_busy_c%0d", c), 256'(nb_busy), 256'(c <= 8));
      check($sformatf("n1_done_c%0d", c), 256'(nb_done), 256'(c == 9));
      check($sformatf("n1_hb_done_c%0d", c), 256'(hb_done), 256'(c == 9));
      check("nobias_valid", 256'(nb_bv), 256'(0));
      check("nobias_data", 256'(nb_b), 256'(0));
      tick();
    end

    // two samples, weight_ready toggling: order, hold, no loss or duplication
    n_samples = CW'(2);
    start     = 1'b1;
    tick();
    start = 1'b0;
    idx   = 0;
    dones = 0;
    for (int c = 1; c < 80 && dones == 0; c++) begin
      weight_ready = (c % 2 == 0);
      if (nb_wv) begin
        check("toggle_word", 256'(nb_w), 256'(exp_w(idx % 6)));
        if (weight_ready) idx++;
      end
      if (nb_done) dones++;
      tick();
    end
    check("toggle_count", 256'(idx), 256'(12));
    check("toggle_done_seen", 256'(dones), 256'(1));
    check("toggle_done_pulse", 256'(nb_done), 256'(0));
    tick();

    // bias channel stalled until the weight stream completes
    weight_ready = 1'b1;
    bias_ready   = 1'b0;
    n_samples    = CW'(2);
    start        = 1'b1;
    tick();
    start    = 1'b0;
    wc       = 0;
    bc       = 0;
    hb_dones = 0;
    for (int c = 1; c < 80 && hb_dones == 0; c++) begin
      bias_ready = (wc >= 12);
      if (hb_wv) begin
        check("bias_run_word", 256'(hb_w), 256'(exp_w(wc % 6)));
        wc++;
      end
      if (hb_bv) begin
        check("bias_run_bias", 256'(hb_b), 256'(exp_b(bc % 2)));
        if (bias_ready) bc++;
      end
      if (hb_done) begin
        hb_dones++;
        check("bias_run_done_after_bias", 256'(bc), 256'(4));
        check("bias_run_wcount", 256'(wc), 256'(12));
      end else begin
        check("bias_run_busy", 256'(hb_busy), 256'(1));
      end
      tick();
    end
    check("bias_run_done_seen", 256'(hb_dones), 256'(1));
    bias_ready = 1'b1;
    tick();

    // zero samples: immediate done, nothing streamed
    n_samples = '0;
    start     = 1'b1;
    tick();
    start = 1'b0;
    check("zero_done_nb", 256'(nb_done), 256'(1));
    check("zero_done_hb", 256'(hb_done), 256'(1));
    check("zero_busy", 256'(nb_busy), 256'(0));
    check("zero_wvalid", 256'(nb_wv), 256'(0));
    check("zero_bvalid", 256'(hb_bv), 256'(0));
    tick();
    check("zero_done_low", 256'(nb_done), 256'(0));
    check("zero_busy_low", 256'(hb_busy), 256'(0));

    // write and restart attempts while busy are ignored
    weight_ready = 1'b0;
    n_samples    = CW'(1);
    start        = 1'b1;
    tick();
    start = 1'b0;
    check("busy_wr_ready", 256'(nb_wr_ready), 256'(0));
    w_wr_en   = 1'b1;
    w_wr_addr = '0;
    w_wr_data = '1;
    start     = 1'b1;
    n_samples = CW'(5);
    tick();
    w_wr_en      = 1'b0;
    start        = 1'b0;
    weight_ready = 1'b1;
    idx          = 0;
    dones        = 0;
    for (int c = 2; c < 40 && dones == 0; c++) begin
      if (nb_wv) begin
        check("busy_run_word", 256'(nb_w), 256'(exp_w(idx % 6)));
        idx++;
      end
      if (nb_done) dones++;
      tick();
    end
    check("busy_run_count", 256'(idx), 256'(6));
    check("busy_run_done", 256'(dones), 256'(1));
    stream_run("rerun_after_drop");

    // reset mid-run after three weight beats
    weight_ready = 1'b1;
    n_samples    = CW'(1);
    start        = 1'b1;
    tick();
    start = 1'b0;
    repeat (4) tick();
    rst = 1'b0;
    #1;
    check("abort_wvalid", 256'(nb_wv), 256'(0));
    check("abort_bvalid", 256'(hb_bv), 256'(0));
    check("abort_busy", 256'(nb_busy), 256'(0));
    check("abort_done", 256'(nb_done), 256'(0));
    check("abort_weight", 256'(nb_w), 256'(0));
    check("abort_wr_ready", 256'(nb_wr_ready), 256'(1));
    tick();
    rst = 1'b1;
    for (int c = 0; c < 4; c++) begin
      check("abort_no_done", 256'(nb_done | hb_done), 256'(0));
      tick();
    end
    stream_run("replay_after_abort");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/fixed_linear_param_source.md
FIXED_LINEAR_PARAM_SOURCE -- requirements
Module: fixed_linear_param_source

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset; reset port `rst` is active-low despite its name.
REQ-002 Parameters (name, default, meaning):
- PARALLELISM, 2, output channels per beat.
- IN_0_SIZE, 4, input elements per beat.
- IN_0_DEPTH, 3, beats per dot product.
- OUT_DEPTH, 2, output-channel blocks (out_features/PARALLELISM).
- WEIGHT_WIDTH, 16, weight element width.
- BIAS_WIDTH, 32, bias element width.
- HAS_BIAS, 0, enables the bias stream.
- CNT_WIDTH, 16, sample-count width.

Derived:
- WEIGHT_SIZE = IN_0_SIZE*PARALLELISM.
- W_DEPTH = OUT_DEPTH*IN_0_DEPTH.
- W_AW = max(1,clog2(W_DEPTH)).
- B_AW = max(1,clog2(OUT_DEPTH)).

REQ-003 Ports (name, direction, width, meaning):
- clk, in, 1, clock.
- rst, in, 1, async active-low reset.
- w_wr_en, in, 1, weight-store write strobe.
- w_wr_addr, in, W_AW, weight word address = o*IN_0_DEPTH+d.
- w_wr_data, in, WEIGHT_WIDTH x [WEIGHT_SIZE], weight word.
- b_wr_en, in, 1, bias-store write strobe.
- b_wr_addr, in, B_AW, bias block address.
- b_wr_data, in, BIAS_WIDTH x [PARALLELISM], bias word.
- wr_ready, out, 1, writes accepted (high only in IDLE).
- start, in, 1, launch pulse.
- n_samples, in, CNT_WIDTH, input vectors to serve; sampled at start.
- busy, out, 1, high in RUN.
- done, out, 1, one-cycle completion pulse.
- weight, out, WEIGHT_WIDTH x [WEIGHT_SIZE], weight beat.
- weight_valid, out, 1, weight beat valid.
- weight_ready, in, 1, weight beat accepted.
- bias, out, BIAS_WIDTH x [PARALLELISM], bias beat.
- bias_valid, out, 1, bias beat valid.
- bias_ready, in, 1, bias beat accepted.

Function
REQ-004 The block SHALL transmit weight/bias streams in the order a PARALLELISM-wide linear consumer expects: for s in 0..n_samples-1, for o in 0..OUT_DEPTH-1, for d in 0..IN_0_DEPTH-1, emit weight word o*IN_0_DEPTH+d.
REQ-005 Element k of a weight word SHALL be the weight for output channel k/IN_0_SIZE, input lane k%IN_0_SIZE.
REQ-006 If HAS_BIAS=1, one bias beat (bias word o) SHALL be emitted per (s,o), on an independent channel with its own counters.
REQ-007 If HAS_BIAS=0, bias_valid SHALL stay 0 and bias SHALL stay 0.
REQ-008 The FSM SHALL have two states:
- IDLE to RUN on start=1 with n_samples!=0.
- RUN to IDLE on the cycle the final weight handshake and (if HAS_BIAS) the final bias handshake have both completed.
REQ-009 start with n_samples=0 SHALL stay in IDLE, emit no beats, and pulse done the next cycle.
REQ-010 start while busy SHALL be ignored.
REQ-011 Writes SHALL be accepted only when wr_ready=1; writes while busy SHALL be dropped.
REQ-012 Simultaneous w_wr_en and b_wr_en SHALL both take effect.
REQ-013 Store reads SHALL be synchronous (1-cycle).
REQ-014 Each channel SHALL have a registered output with prefetch, so the first valid beat appears 2 cycles after the start cycle.
REQ-015 With ready held high, each channel SHALL sustain one beat per cycle with no bubbles, including across o, s and store wrap boundaries.
REQ-016 While valid=1 and ready=0, data SHALL be held stable, and valid SHALL not drop until handshake.
REQ-017 Once all beats of a channel are handshaken, that channel's valid SHALL deassert the next cycle.
REQ-018 done SHALL pulse for exactly one cycle, the cycle after the transition to IDLE; busy SHALL fall on the same edge.
REQ-019 The d counter SHALL wrap at IN_0_DEPTH-1, then o SHALL wrap at OUT_DEPTH-1, then s SHALL increment; on the final (s,o,d) no further reads SHALL issue.
REQ-020 Store contents SHALL be unchanged by streaming and persist across runs.

Reset
REQ-021 While rst=0 the following outputs SHALL be 0: weight_valid, bias_valid, busy, done, weight, bias. All counters SHALL be 0, the FSM SHALL be in IDLE, and wr_ready SHALL be 1.
REQ-022 Store contents SHALL not be reset; reads before a write return undefined data.
REQ-023 Reset asserted mid-run SHALL abort the run without a done pulse, and the block SHALL accept a new start after release.

Verification (defaults: P=2, IN_0_SIZE=4, IN_0_DEPTH=3, OUT_DEPTH=2)
REQ-024 Load words 0..5 with element k of word a = 16*a+k, start n_samples=1, ready=1 -> 6 beats appear in cycles start+2..start+7, in word order 0..5; done pulses at start+9.
REQ-025 Same load, n_samples=2, weight_ready toggling 1,0,1,0 -> 12 beats, ordered 0..5,0..5, each held stable while ready=0; no beat is duplicated or lost.
REQ-026 HAS_BIAS=1, bias word o = {100+o,200+o}, n_samples=2, bias_ready=0 until the weight stream ends -> weight stream completes; bias beats are then o=0,1,0,1; done pulses only after the 4th bias handshake.
REQ-027 start with n_samples=0 -> no valid; done=1 for one cycle; busy stays 0.
REQ-028 A write to word 0 during RUN is dropped (word 0 unchanged on the next run), and start while busy does not restart the counters.
REQ-029 rst=0 pulsed after 3 weight beats -> all outputs 0 immediately, no done; a new start then replays from word 0 with the store intact.
